// File: rtl/axi_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read master port among NUM_REQ requesters, one read in flight.
// Optional watchdog abort (SLVERR, timeout pulse) is built when AXIL_RD_ARB_TIMEOUT_EN is defined.
module axi_lite_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic                      timeout,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi_lite_read_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, AR = 2'd1, R = 2'd2, RSP = 2'd3} state_t;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // a valid, once raised, stays high with its payload stable until that transfer completes.
  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   idx_w;
  logic               pick_any;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [NUM_REQ-1:0] gnt_oh;

  assign dbg_state = state;
  assign nxt_ptr   = (gnt == PTR_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
  assign gnt_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;

  always_comb begin
    int idx;
    idx      = 0;
    idx_w    = '0;
    pick     = '0;
    pick_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!pick_any && req_valid[idx_w]) begin
        pick     = idx_w;
        pick_any = 1'b1;
      end
    end
  end

  // Accept is combinational but suppressed during reset so every output reads as reset value.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && pick_any && !ARESET) req_ready[pick] = 1'b1;
  end

`ifdef AXIL_RD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_abort;

  assign wd_abort = ((state == AR && !ARREADY) || (state == R && !RVALID)) &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef AXIL_RD_ARB_TIMEOUT_EN
      timeout <= 1'b0;
      if (state == AR || state == R) wd_cnt <= wd_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            ARADDR  <= req_addr[pick*ADDR_W +: ADDR_W];
            gnt     <= pick;
            ARVALID <= 1'b1;
            state   <= AR;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end
        end
        AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            rsp_data  <= RDATA;
            rsp_resp  <= RRESP;
            rsp_valid <= gnt_oh;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            rr_ptr    <= nxt_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_RD_ARB_TIMEOUT_EN
      // Watchdog abort answers the requester with SLVERR and no data.
      if (wd_abort) begin
        ARVALID   <= 1'b0;
        RREADY    <= 1'b0;
        rsp_data  <= '0;
        rsp_resp  <= 2'b10;
        rsp_valid <= gnt_oh;
        timeout   <= 1'b1;
        state     <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Bench for axi_lite_read_arbiter: table of read transactions through a scripted subordinate,
// plus hand sequences for mid-transaction reset and the watchdog (AXIL_RD_ARB_TIMEOUT_EN).
module tb_axi_lite_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  req_valid;
  logic [127:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        timeout;
  logic [1:0]  dbg_state;

  axi_lite_read_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  int total = 0;
  int bad   = 0;
  logic [69:0] exp_q[$];   // {grant[3:0], resp[1:0], data[63:0]}

  typedef struct {
    logic [3:0]  mask;
    int          g;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    int          ar_w;
    int          r_w;
    int          rsp_w;
  } vec_t;

  vec_t vecs[14];
  vec_t vpost;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  task automatic wait_grant(input int g);
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    chk("grant", {66'b0, req_ready}, {66'b0, oh(g)});
  endtask

  // driver: one full read through a subordinate with scripted wait states
  task automatic do_txn(input vec_t v);
    logic [69:0] e;
    req_addr[v.g*32 +: 32] = v.addr;
    req_valid = v.mask;
    exp_q.push_back({4'(v.g), v.rresp, v.rdata});
    wait_grant(v.g);
    for (int i = 0; i <= v.ar_w; i++) begin
      @(negedge ACLK);
      chk("ar_arvalid", {69'b0, ARVALID}, 70'd1);
      chk("ar_araddr", {38'b0, ARADDR}, {38'b0, v.addr});
      chk("ar_rready", {69'b0, RREADY}, 70'd0);
      chk("ar_req_ready", {66'b0, req_ready}, 70'd0);
      ARREADY = (i == v.ar_w);
    end
    for (int i = 0; i <= v.r_w; i++) begin
      @(negedge ACLK);
      ARREADY = 1'b0;
      chk("r_arvalid", {69'b0, ARVALID}, 70'd0);
      chk("r_rready", {69'b0, RREADY}, 70'd1);
      chk("r_req_ready", {66'b0, req_ready}, 70'd0);
      RVALID = (i == v.r_w);
      RDATA  = (i == v.r_w) ? v.rdata : {$urandom, $urandom};
      RRESP  = (i == v.r_w) ? v.rresp : 2'($urandom_range(0, 3));
    end
    for (int i = 0; i <= v.rsp_w; i++) begin
      @(negedge ACLK);
      RVALID = 1'b0;
      RDATA  = {$urandom, $urandom};
      chk("rsp_valid", {66'b0, rsp_valid}, {66'b0, oh(v.g)});
      chk("rsp_rready", {69'b0, RREADY}, 70'd0);
      chk("rsp_req_ready", {66'b0, req_ready}, 70'd0);
      if (exp_q.size() == 0) begin
        chk("sb_empty", 70'd1, 70'd0);
      end else begin
        e = (i == v.rsp_w) ? exp_q.pop_front() : exp_q[0];
        chk("rsp_data", {6'b0, rsp_data}, {6'b0, e[63:0]});
        chk("rsp_resp", {68'b0, rsp_resp}, {68'b0, e[65:64]});
      end
      rsp_ready = (i == v.rsp_w) ? oh(v.g) : ~oh(v.g);
    end
    @(negedge ACLK);
    rsp_ready = 4'b0;
    chk("rsp_done", {66'b0, rsp_valid}, 70'd0);
  endtask

  initial begin
    int n;
    ARESET = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = '0;
    ARREADY = 1'b0; RDATA = '0; RRESP = '0; RVALID = 1'b0;

    vecs[0] = '{4'b0100, 2, 32'h0000_1040, 64'hDEAD_BEEF_0000_0001, 2'b00, 0, 0, 0};
    vecs[1] = '{4'b0010, 1, 32'h0000_2224, 64'h1111_2222_3333_4444, 2'b11, 0, 0, 0};
    vecs[2] = '{4'b1011, 3, 32'h0000_3F00, 64'h0BAD_F00D_CAFE_0042, 2'b01, 5, 7, 3};
    for (int k = 0; k < 8; k++)
      vecs[3+k] = '{4'b1111, k % 4, 32'h2000 + 32'(k*8), {$urandom, $urandom}, 2'(k % 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2)};
    vecs[11] = '{4'b1001, 0, 32'h0000_4000, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 1, 0};
    vecs[12] = '{4'b1001, 3, 32'h0000_4004, 64'hFEDC_BA98_7654_3210, 2'b10, 1, 0, 1};
    vecs[13] = '{4'b0100, 2, 32'h0000_5000, 64'h5555_AAAA_5555_AAAA, 2'b00, 0, 0, 0};
    vpost    = '{4'b1111, 0, 32'h0000_6000, 64'h6666_0000_0000_6666, 2'b00, 0, 0, 0};

    repeat (3) @(negedge ACLK);
    chk("rst_state", {68'b0, dbg_state}, 70'd0);
    chk("rst_arvalid", {69'b0, ARVALID}, 70'd0);
    chk("rst_rready", {69'b0, RREADY}, 70'd0);
    chk("rst_rsp_valid", {66'b0, rsp_valid}, 70'd0);
    chk("rst_outputs", {ARADDR, rsp_data, rsp_resp, timeout, req_ready}, 70'd0);
    ARESET = 1'b0;

    for (int i = 0; i < 14; i++) do_txn(vecs[i]);

    // reset while in R; rr_ptr is 3 here so a post-reset grant of 0 shows the pointer cleared
    req_valid = 4'b0010;
    req_addr[32 +: 32] = 32'h0000_7000;
    wait_grant(1);
    @(negedge ACLK);
    chk("mr_arvalid", {69'b0, ARVALID}, 70'd1);
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    chk("mr_rready", {69'b0, RREADY}, 70'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("mr_ctrl", {ARVALID, RREADY, timeout, rsp_valid, req_ready}, 70'd0);
    chk("mr_data", {ARADDR, rsp_data, rsp_resp}, 70'd0);
    ARESET = 1'b0;
    do_txn(vpost);

    // watchdog: subordinate never answers on R
    req_valid = 4'b0010;
    wait_grant(1);
    @(negedge ACLK);
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
    n = 0;
    while (RREADY === 1'b1 && n < 40) begin
      n++;
      @(negedge ACLK);
    end
    chk("to_r_cycles", 70'(n), 70'd15);
    chk("to_pulse", {69'b0, timeout}, 70'd1);
    chk("to_rsp_valid", {66'b0, rsp_valid}, 70'b0010);
    chk("to_rsp_resp", {68'b0, rsp_resp}, 70'b10);
    chk("to_rsp_data", {6'b0, rsp_data}, 70'd0);
    rsp_ready = 4'b0010;
    @(negedge ACLK);
    rsp_ready = 4'b0;
    chk("to_pulse_end", {69'b0, timeout}, 70'd0);
    chk("to_rsp_done", {66'b0, rsp_valid}, 70'd0);
`else
    n = 0;
    repeat (1000) begin
      @(negedge ACLK);
      if (timeout !== 1'b0) n++;
    end
    chk("nto_rready", {69'b0, RREADY}, 70'd1);
    chk("nto_no_pulse", 70'(n), 70'd0);
    chk("nto_rsp_valid", {66'b0, rsp_valid}, 70'd0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
`endif

    chk("sb_drained", 70'(exp_q.size()), 70'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
